// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop synchroniser, falling-edge start detect,
// centre sampling of each bit, one-cycle data_valid / frame_error strobes.
module uart_receiver #(
    parameter int unsigned BIT_CYCLES  = 5201,
    parameter int unsigned HALF_CYCLES = BIT_CYCLES / 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_error,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [15:0] BIT_LAST  = 16'(BIT_CYCLES - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_CYCLES - 1);

    state_t      state;
    logic [15:0] counter;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        s1, s2, s2_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            s2_d <= 1'b1;
        end else begin
            s1   <= rx;
            s2   <= s1;
            s2_d <= s2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            counter     <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
            busy        <= 1'b0;
        end else begin
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
            case (state)
                IDLE: begin
                    // Edge, not level: a line parked low never restarts a frame.
                    if (!s2 && s2_d) begin
                        state   <= START;
                        counter <= '0;
                        busy    <= 1'b1;
                    end
                end
                START: begin
                    if (counter == HALF_LAST) begin
                        counter <= '0;
                        if (!s2) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        counter <= counter + 16'd1;
                    end
                end
                DATA: begin
                    if (counter == BIT_LAST) begin
                        counter <= '0;
                        shift   <= {s2, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        counter <= counter + 16'd1;
                    end
                end
                STOP: begin
                    if (counter == BIT_LAST) begin
                        counter <= '0;
                        state   <= IDLE;
                        busy    <= 1'b0;
                        if (s2) begin
                            data_out   <= shift;
                            data_valid <= 1'b1;
                        end else begin
                            frame_error <= 1'b1;
                        end
                    end else begin
                        counter <= counter + 16'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    counter <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: two instances (odd and even bit period) driven by a
// behavioural transmitter; expected strobes come from frame-level arithmetic.
module tb_uart_receiver;

    localparam int BA = 37;
    localparam int HA = BA / 2;
    localparam int BB = 16;
    localparam int HB = BB / 2;

    typedef struct {
        int         t;
        logic [7:0] data;
        logic       dv;
        logic       fe;
        logic       busy;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_a, rst_b, rx_a, rx_b;
    logic [7:0] dout_a, dout_b;
    logic       dv_a, dv_b, fe_a, fe_b, busy_a, busy_b;

    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] last_good [2];
    ev_t        exp_a[$], exp_b[$], obs_a[$], obs_b[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_receiver #(.BIT_CYCLES(BA)) dut_a (
        .clk(clk), .reset(rst_a), .rx(rx_a), .data_out(dout_a),
        .data_valid(dv_a), .frame_error(fe_a), .busy(busy_a)
    );

    uart_receiver #(.BIT_CYCLES(BB)) dut_b (
        .clk(clk), .reset(rst_b), .rx(rx_b), .data_out(dout_b),
        .data_valid(dv_b), .frame_error(fe_b), .busy(busy_b)
    );

    always @(negedge clk) begin
        if (dv_a || fe_a) obs_a.push_back('{t:cyc, data:dout_a, dv:dv_a, fe:fe_a, busy:busy_a});
        if (dv_b || fe_b) obs_b.push_back('{t:cyc, data:dout_b, dv:dv_b, fe:fe_b, busy:busy_b});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int bitc(input int d);
        return (d == 0) ? BA : BB;
    endfunction

    function automatic int halfc(input int d);
        return (d == 0) ? HA : HB;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_rx(input int d, input logic v);
        if (d == 0) rx_a = v;
        else        rx_b = v;
    endtask

    // Drives one 8N1 frame and records the strobe the receiver owes for it.
    task automatic send_frame(input int d, input logic [7:0] b, input logic stop_ok, input logic hold_low);
        ev_t e;
        int  bc;
        bc = bitc(d);
        set_rx(d, 1'b0);
        e.t = cyc + halfc(d) + 9 * bc + 3;
        tick(bc);
        for (int i = 0; i < 8; i++) begin
            set_rx(d, b[i]);
            tick(bc);
        end
        set_rx(d, stop_ok);
        tick(bc);
        if (!hold_low) set_rx(d, 1'b1);
        if (stop_ok) last_good[d] = b;
        e.data = last_good[d];
        e.dv   = stop_ok;
        e.fe   = !stop_ok;
        e.busy = 1'b0;
        if (d == 0) exp_a.push_back(e);
        else        exp_b.push_back(e);
    endtask

    task automatic drain(input int d);
        ev_t o, e;
        int  n_o, n_e, dt;
        tick(2 * bitc(d));
        n_o = (d == 0) ? obs_a.size() : obs_b.size();
        n_e = (d == 0) ? exp_a.size() : exp_b.size();
        check($sformatf("count%0d", d), n_o, n_e);
        for (int i = 0; i < n_e && i < n_o; i++) begin
            if (d == 0) begin o = obs_a[i]; e = exp_a[i]; end
            else        begin o = obs_b[i]; e = exp_b[i]; end
            check($sformatf("dv%0d_%0d", d, i), o.dv, e.dv);
            check($sformatf("fe%0d_%0d", d, i), o.fe, e.fe);
            check($sformatf("data%0d_%0d", d, i), o.data, e.data);
            check($sformatf("busy%0d_%0d", d, i), o.busy, e.busy);
            dt = o.t - e.t;
            check($sformatf("lat%0d_%0d", d, i), (dt >= -1 && dt <= 1) ? e.t : o.t, e.t);
        end
        obs_a.delete(); obs_b.delete();
        if (d == 0) exp_a.delete();
        else        exp_b.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int   diff, gap;
        logic err, prev_err;
        logic [7:0] b;

        rx_a = 1'b1; rx_b = 1'b1; rst_a = 1'b1; rst_b = 1'b1;
        last_good[0] = '0; last_good[1] = '0;
        tick(3);
        @(negedge clk);
        check("rst_dout", dout_a, 8'h00);
        check("rst_dv", dv_a, 1'b0);
        check("rst_fe", fe_a, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        @(posedge clk); #1;
        rst_a = 1'b0; rst_b = 1'b0;
        tick(2 * BA);

        send_frame(0, 8'hA5, 1'b1, 1'b0);
        drain(0);
        check("a5_busy_after", busy_a, 1'b0);

        send_frame(0, 8'h00, 1'b1, 1'b0);
        send_frame(0, 8'hFF, 1'b1, 1'b0);
        tick(BA);
        diff = (obs_a.size() >= 2) ? obs_a[1].t - obs_a[0].t : -1;
        check("b2b_gap", (diff >= 10 * BA - 2 && diff <= 10 * BA + 2) ? 10 * BA : diff, 10 * BA);
        drain(0);

        set_rx(0, 1'b0);
        tick(4);
        check("glitch_busy_hi", busy_a, 1'b1);
        tick(1);
        set_rx(0, 1'b1);
        tick(HA + 5);
        check("glitch_busy_lo", busy_a, 1'b0);
        drain(0);
        check("glitch_dout", dout_a, last_good[0]);

        send_frame(0, 8'h3C, 1'b0, 1'b1);
        tick(3 * BA);
        check("break_busy", busy_a, 1'b0);
        drain(0);
        check("break_dout", dout_a, last_good[0]);
        set_rx(0, 1'b1);
        tick(BA);
        send_frame(0, 8'h96, 1'b1, 1'b0);
        drain(0);

        b = 8'h5A;
        set_rx(0, 1'b0);
        tick(BA);
        for (int i = 0; i < 3; i++) begin
            set_rx(0, b[i]);
            tick(BA);
        end
        set_rx(0, b[3]);
        tick(BA / 2);
        rst_a = 1'b1;
        tick(1);
        rst_a = 1'b0;
        check("rst_mid_busy", busy_a, 1'b0);
        set_rx(0, 1'b1);
        last_good[0] = '0;
        tick(12 * BA);
        drain(0);
        check("rst_mid_dout", dout_a, 8'h00);
        send_frame(0, 8'h81, 1'b1, 1'b0);
        drain(0);

        send_frame(1, 8'h01, 1'b1, 1'b0);
        send_frame(1, 8'h80, 1'b1, 1'b0);
        tick($urandom_range(0, 3));
        send_frame(1, 8'h55, 1'b1, 1'b0);
        drain(1);

        for (int d = 0; d < 2; d++) begin
            prev_err = 1'b0;
            for (int k = 0; k < 20; k++) begin
                gap = prev_err ? $urandom_range(1, 2) : $urandom_range(0, 2);
                tick(gap * bitc(d) + $urandom_range(0, 3));
                err = ($urandom_range(0, 4) == 0);
                send_frame(d, 8'($urandom_range(0, 255)), !err, 1'b0);
                prev_err = err;
            end
            drain(d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
